// File: rtl/subn_pkg.sv
// Shared types and helpers for the digit-serial subtractor subn_serial.
// Optional signed-overflow output is enabled by defining SUBN_OVF_EN.
package subn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } subn_state_e;

  // Chunk counter width; a single-chunk build still needs a 1-bit counter.
  function automatic int cnt_width(input int n_bits, input int digit_w);
    int w;
    w = $clog2(n_bits / digit_w);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/subn_digit.sv
// Combinational W-bit subtract cell: {bout, Dc} = Xc - Yc - bin.
module subn_digit #(
  parameter int W = 4
) (
  input  logic [W-1:0] xc,
  input  logic [W-1:0] yc,
  input  logic         bin,
  output logic [W-1:0] dc,
  output logic         bout
);

  logic [W:0] diff;

  // The extra top bit goes to 1 exactly when the chunk result is negative.
  assign diff = {1'b0, xc} - {1'b0, yc} - {{W{1'b0}}, bin};
  assign dc   = diff[W-1:0];
  assign bout = diff[W];

endmodule

// File: rtl/subn_serial.sv
// Digit-serial n-bit subtractor D = X - Y - borrowin, W bits per cycle, valid/ready on both sides.
// Define SUBN_OVF_EN to add the ovf output (two's-complement overflow of the subtraction).
module subn_serial
  import subn_pkg::*;
#(
  parameter int n = 16,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         sreset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         borrowin,
  input  logic [n-1:0] X,
  input  logic [n-1:0] Y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n-1:0] D,
`ifdef SUBN_OVF_EN
  output logic         ovf,
`endif
  output logic         borrowout
);

  localparam int CW     = cnt_width(n, W);
  localparam int NCHUNK = n / W;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  subn_state_e   state_q;
  logic [CW-1:0] cnt_q;
  logic          b_q;
  logic [n-1:0]  x_q;
  logic [n-1:0]  y_q;
  logic [n-1:0]  res_q;
  logic [n-1:0]  res_d;
  logic [n-1:0]  d_q;
  logic          bo_q;
  logic          in_ready_q;
  logic          out_valid_q;
`ifdef SUBN_OVF_EN
  logic          ovf_q;
`endif

  int            base;
  logic [W-1:0]  xc;
  logic [W-1:0]  yc;
  logic [W-1:0]  dc;
  logic          bout;

  assign base = int'(cnt_q) * W;
  assign xc   = x_q[base +: W];
  assign yc   = y_q[base +: W];

  // One cell, time-multiplexed across the chunks by cnt_q.
  subn_digit #(.W(W)) u_digit (
    .xc   (xc),
    .yc   (yc),
    .bin  (b_q),
    .dc   (dc),
    .bout (bout)
  );

  // Partial result with the current chunk merged in; on the last chunk this is the full D.
  always_comb begin
    res_d            = res_q;
    res_d[base +: W] = dc;
  end

  always_ff @(posedge clk) begin
    if (sreset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      b_q         <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      res_q       <= '0;
      d_q         <= '0;
      bo_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef SUBN_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            x_q        <= X;
            y_q        <= Y;
            b_q        <= borrowin;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          res_q <= res_d;
          b_q   <= bout;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            cnt_q       <= '0;
            d_q         <= res_d;
            bo_q        <= bout;
            out_valid_q <= 1'b1;
`ifdef SUBN_OVF_EN
            ovf_q       <= (x_q[n-1] != y_q[n-1]) && (res_d[n-1] != x_q[n-1]);
`endif
            state_q     <= DONE;
          end
        end
        DONE: begin
          // Inputs are deliberately not looked at here: no accept-on-handshake bypass.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign D         = d_q;
  assign borrowout = bo_q;
`ifdef SUBN_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_subn_serial.sv
// Directed bench for subn_serial (n=16, W=4); ovf checks are compiled in with SUBN_OVF_EN.
module tb_subn_serial;

  logic        clk;
  logic        sreset;
  logic        in_valid;
  logic        in_ready;
  logic        borrowin;
  logic [15:0] X;
  logic [15:0] Y;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] D;
  logic        borrowout;
`ifdef SUBN_OVF_EN
  logic        ovf;
`endif

  int n_checks = 0;
  int n_err    = 0;

  subn_serial #(.n(16), .W(4)) dut (
    .clk       (clk),
    .sreset    (sreset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .borrowin  (borrowin),
    .X         (X),
    .Y         (Y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (D),
`ifdef SUBN_OVF_EN
    .ovf       (ovf),
`endif
    .borrowout (borrowout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called #1 after a clock edge with the DUT in IDLE.
  task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic bi,
                        input logic [15:0] exp_d, input logic exp_b, input logic exp_ovf,
                        input logic do_handshake);
    int lat;
    X = x; Y = y; borrowin = bi; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; X = 16'hDEAD; Y = 16'hBEEF; borrowin = ~bi;
    check("in_ready_run", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, 4);
    check("D", D, exp_d);
    check("borrowout", borrowout, exp_b);
    check("in_ready_done", in_ready, 0);
`ifdef SUBN_OVF_EN
    check("ovf", ovf, exp_ovf);
`else
    if (exp_ovf) $display("note: ovf expectation not checked in this build");
`endif
    $display("op X=%04h Y=%04h bin=%0b -> D=%04h bout=%0b (lat %0d)", x, y, bi, D, borrowout, lat);
    if (do_handshake) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("out_valid_after_hs", out_valid, 0);
      check("in_ready_after_hs", in_ready, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] held_d;
    sreset = 1'b1; in_valid = 1'b0; borrowin = 1'b0; X = '0; Y = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_D", D, 0);
    check("rst_borrowout", borrowout, 0);
    sreset = 1'b0;
    @(posedge clk); #1;

    run_op(16'h0005, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b1);
    run_op(16'h0002, 16'h0005, 1'b0, 16'hFFFD, 1'b1, 1'b0, 1'b1);
    run_op(16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b1);
    run_op(16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1);

    // Backpressure: hold the result for 6 cycles while poking in_valid.
    out_ready = 1'b0;
    run_op(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
    held_d = D;
    for (int i = 0; i < 6; i++) begin
      in_valid = i[0]; X = 16'h5555; Y = 16'h1111;
      @(posedge clk); #1;
      check("bp_out_valid", out_valid, 1);
      check("bp_D", D, {16'h0, held_d});
      check("bp_borrowout", borrowout, 0);
      check("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_hs_out_valid", out_valid, 0);
    check("bp_hs_in_ready", in_ready, 1);
    $display("backpressure held D=%04h for 6 cycles, released", held_d);
    run_op(16'h00F0, 16'h0010, 1'b0, 16'h00E0, 1'b0, 1'b0, 1'b1);

    // Reset during the second RUN cycle aborts the operation.
    X = 16'h00FF; Y = 16'h0001; borrowin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    sreset = 1'b1;
    @(posedge clk); #1;
    sreset = 1'b0;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_D", D, 0);
    check("abort_borrowout", borrowout, 0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("abort_no_result", out_valid, 0);
    end
    $display("reset mid-RUN: operation aborted");
    run_op(16'h0009, 16'h0004, 1'b0, 16'h0005, 1'b0, 1'b0, 1'b1);

`ifdef SUBN_OVF_EN
    run_op(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b1);
    run_op(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
